// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioner: button indices and vector type.
package btn_pkg;

  localparam int unsigned NUM_BTN = 5;

  // Bit positions within every button vector, {center, right, left, down, up}.
  localparam int unsigned BTN_UP     = 0;
  localparam int unsigned BTN_DOWN   = 1;
  localparam int unsigned BTN_LEFT   = 2;
  localparam int unsigned BTN_RIGHT  = 3;
  localparam int unsigned BTN_CENTER = 4;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: pad synchroniser, stability counter, clean level and rising-edge pulse.
module debounce_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Plain shift chain into the clock domain; bit 0 is the metastability-exposed stage.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  // Accept a new level only after it has disagreed with the stable level long enough.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d   = '0;
      level_d = sync;
      // Pulse only on accepted 0->1; sync is the new level here.
      press_d = sync;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Cleans the five raw push buttons into debounced levels and one-cycle press pulses.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic               any_press
);

  btn_vec_t level;
  btn_vec_t press;

  // Channels are independent; direction priority is resolved downstream.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) u_chan (
      .clk_i  (clk),
      .reset_i(reset),
      .raw_i  (btn_raw[i]),
      .level_o(level[i]),
      .press_o(press[i])
    );
  end

  assign btn_level = level;
  assign btn_press = press;
  // OR of flop outputs only, so still no path from btn_raw.
  assign any_press = |press;

endmodule
